fetch_unit: RTL and testbench

Instruction fetch stage that drives the program counter register and feeds decode. Reads the current PC and runs a req/ack transfer with instruction memory. Presents each fetched word to decode through a valid/ready handshake. Sequences every PC update, either increment or branch redirect, through `pc_cmd`/`pc_datain`, and squashes fetches made stale by a redirect.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU constants and fetch-stage state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;

    localparam int unsigned PC_RESET = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2,
        HOLD   = 2'd3
    } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: PC sequencing, imem req/ack, decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_cmd,
    output logic [ADDR_W-1:0] pc_datain,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_ir_data;
    logic [ADDR_W-1:0] r_ir_pc;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_enter_req;
    logic              w_capture;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (imem_ack) begin
                    w_state_nxt = branch_valid ? REQ : HOLD;
                end else if (branch_valid) begin
                    w_state_nxt = SQUASH;
                end
            end
            SQUASH: begin
                if (imem_ack) begin
                    w_state_nxt = REQ;
                end
            end
            HOLD: begin
                if (branch_valid || ir_ready) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Waiting in REQ without an ack is not a fresh entry, so addr_q stays put.
    assign w_enter_req = (w_state_nxt == REQ) && !((r_state == REQ) && !imem_ack);
    assign w_capture   = (r_state == REQ) && imem_ack && !branch_valid;
    assign w_addr_inc  = r_addr_q + ADDR_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr_q  <= ADDR_W'(PC_RESET);
            r_ir_data <= '0;
            r_ir_pc   <= ADDR_W'(PC_RESET);
        end else begin
            if (w_enter_req) begin
                r_addr_q <= branch_valid ? branch_target : pc_value;
            end
            if (w_capture) begin
                r_ir_data <= imem_rdata;
                r_ir_pc   <= r_addr_q;
            end
        end
    end

    always_comb begin
        imem_req  = (r_state == REQ) || (r_state == SQUASH);
        ir_valid  = (r_state == HOLD) && !branch_valid;
        pc_cmd    = 1'b0;
        pc_datain = '0;
        // Redirect wins over the sequential increment; a squashed ack never increments.
        if (reset) begin
            if (branch_valid) begin
                pc_cmd    = 1'b1;
                pc_datain = branch_target;
            end else if ((r_state == REQ) && imem_ack) begin
                pc_cmd    = 1'b1;
                pc_datain = w_addr_inc;
            end
        end
    end

    assign imem_addr = r_addr_q;
    assign ir_data   = r_ir_data;
    assign ir_pc     = r_ir_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit with an external PC register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [11:0] pc_value;
    logic        pc_cmd;
    logic [11:0] pc_datain;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        branch_valid;
    logic [11:0] branch_target;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [11:0] ir_pc;
    logic        ir_ready;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    fetch_unit #(.ADDR_W(12), .DATA_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_value      (pc_value),
        .pc_cmd        (pc_cmd),
        .pc_datain     (pc_datain),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .ir_valid      (ir_valid),
        .ir_data       (ir_data),
        .ir_pc         (ir_pc),
        .ir_ready      (ir_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The PC register the fetch unit drives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc_value <= 12'h000;
        else if (pc_cmd) pc_value <= pc_datain;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
        branch_valid = 1'b0; branch_target = 12'h0; ir_ready = 1'b1;
        next_cycle(); next_cycle();

        // Reset state
        sample();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_pc_cmd", pc_cmd, 0);
        chk("rst_pc_datain", pc_datain, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_ir_data", ir_data, 0);
        chk("rst_ir_pc", ir_pc, 0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Zero-wait fetch at address 0
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        sample();
        chk("zw_req", imem_req, 1);
        chk("zw_addr", imem_addr, 12'h000);
        chk("zw_pc_cmd", pc_cmd, 1);
        chk("zw_pc_datain", pc_datain, 12'h001);
        next_cycle();
        imem_ack = 1'b0;
        sample();
        chk("zw_ir_valid", ir_valid, 1);
        chk("zw_ir_data", ir_data, 16'h1234);
        chk("zw_ir_pc", ir_pc, 12'h000);
        chk("zw_hold_req", imem_req, 0);
        next_cycle();

        // Late ack: request held for 4 cycles, one pc_cmd pulse
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 3); imem_rdata = 16'hBEEF;
            sample();
            chk("late_req", imem_req, 1);
            chk("late_addr", imem_addr, 12'h001);
            chk("late_pc_cmd", pc_cmd, (i == 3) ? 1 : 0);
            if (pc_cmd) pulses++;
            if (i == 3) chk("late_pc_datain", pc_datain, 12'h002);
            next_cycle();
        end
        imem_ack = 1'b0;
        chk("late_pulses", pulses, 1);

        // Decode stall for 5 cycles
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("stall_ir_valid", ir_valid, 1);
            chk("stall_ir_data", ir_data, 16'hBEEF);
            chk("stall_ir_pc", ir_pc, 12'h001);
            chk("stall_req", imem_req, 0);
            chk("stall_pc_cmd", pc_cmd, 0);
            next_cycle();
        end
        ir_ready = 1'b1;
        sample();
        chk("release_ir_valid", ir_valid, 1);
        next_cycle();

        // Branch to 0x2A0 while request to 0x002 is outstanding
        branch_valid = 1'b1; branch_target = 12'h2A0;
        sample();
        chk("br_req_addr", imem_addr, 12'h002);
        chk("br_req_pc_cmd", pc_cmd, 1);
        chk("br_req_pc_datain", pc_datain, 12'h2A0);
        next_cycle();
        branch_valid = 1'b0;
        sample();
        chk("sq1_req", imem_req, 1);
        chk("sq1_addr", imem_addr, 12'h002);
        chk("sq1_pc_cmd", pc_cmd, 0);
        chk("sq1_ir_valid", ir_valid, 0);
        next_cycle();
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        sample();
        chk("sq2_req", imem_req, 1);
        chk("sq2_addr", imem_addr, 12'h002);
        chk("sq2_pc_cmd", pc_cmd, 0);
        next_cycle();
        imem_rdata = 16'h7777;
        sample();
        chk("br_tgt_req", imem_req, 1);
        chk("br_tgt_addr", imem_addr, 12'h2A0);
        chk("br_tgt_ir_valid", ir_valid, 0);
        chk("br_tgt_pc_datain", pc_datain, 12'h2A1);
        next_cycle();
        imem_ack = 1'b0;
        sample();
        chk("br_tgt_ir_data", ir_data, 16'h7777);
        chk("br_tgt_ir_pc", ir_pc, 12'h2A0);

        // Branch to 0x055 in HOLD with ir_ready high
        branch_valid = 1'b1; branch_target = 12'h055;
        #1;
        chk("hold_br_ir_valid", ir_valid, 0);
        chk("hold_br_pc_cmd", pc_cmd, 1);
        chk("hold_br_pc_datain", pc_datain, 12'h055);
        next_cycle();
        branch_valid = 1'b0;
        sample();
        chk("hold_br_req", imem_req, 1);
        chk("hold_br_addr", imem_addr, 12'h055);
        next_cycle();

        // Redirect to 0xFFF with a same-cycle ack, then wrap
        branch_valid = 1'b1; branch_target = 12'hFFF; imem_ack = 1'b1; imem_rdata = 16'h0BAD;
        sample();
        chk("wrap_br_pc_datain", pc_datain, 12'hFFF);
        next_cycle();
        branch_valid = 1'b0; imem_rdata = 16'hA5A5;
        sample();
        chk("wrap_addr", imem_addr, 12'hFFF);
        chk("wrap_pc_cmd", pc_cmd, 1);
        chk("wrap_pc_datain", pc_datain, 12'h000);
        next_cycle();
        imem_ack = 1'b0;
        sample();
        chk("wrap_ir_valid", ir_valid, 1);
        chk("wrap_ir_pc", ir_pc, 12'hFFF);
        chk("wrap_ir_data", ir_data, 16'hA5A5);
        next_cycle();
        sample();
        chk("wrap_next_addr", imem_addr, 12'h000);
        chk("wrap_next_req", imem_req, 1);

        // Asynchronous reset abandons the outstanding request
        reset = 1'b0;
        #1;
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_pc_cmd", pc_cmd, 0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
